gpu_lsu: RTL

Parametrised load/store unit for the SIMT core. It accepts one warp-wide LW/SW carrying a per-lane address, write data and an active mask, then serialises the active lanes onto a single-port data-memory handshake. Loads are gathered into a per-lane writeback vector. While an operation is in flight it drives `stall` so the core holds the PC; this replaces the fixed 16-lane, unmasked serial memory path.

---
 rtl/gpu_pkg.sv | 15 +
 rtl/gpu_lane_prio_enc.sv | 18 +
 rtl/gpu_lsu.sv | 137 +++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared types and default sizing for the SIMT core load/store path.
package gpu_pkg;
    localparam int LSU_NUM_LANES = 16;
    localparam int LSU_ADDR_W    = 16;
    localparam int LSU_DATA_W    = 16;

    typedef logic [LSU_NUM_LANES-1:0] lane_vec_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        WRITEBACK
    } lsu_state_t;
endpackage

// File: rtl/gpu_lane_prio_enc.sv
// Lowest-set-bit finder over a lane vector; purely combinational.
module gpu_lane_prio_enc #(
    parameter int N = 16,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
    end

    assign any = |vec;
endmodule

// File: rtl/gpu_lsu.sv
// Warp LW/SW serialiser: one memory handshake per active lane (loads 2 cycles/lane, stores 1), then a one-cycle writeback; stall while busy.
// Optional GPU_LSU_COALESCE_EN: a load response also fills every pending lane with the same address.
module gpu_lsu
    import gpu_pkg::*;
#(
    parameter int NUM_LANES = LSU_NUM_LANES,
    parameter int ADDR_W    = LSU_ADDR_W,
    parameter int DATA_W    = LSU_DATA_W,
    localparam int LANE_W   = $clog2(NUM_LANES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [NUM_LANES-1:0]          req_mask,
    input  logic [NUM_LANES*ADDR_W-1:0]   req_addr,
    input  logic [NUM_LANES*DATA_W-1:0]   req_wdata,
    output logic                          stall,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_rsp_valid,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          wb_valid,
    output logic [NUM_LANES-1:0]          wb_mask,
    output logic [NUM_LANES*DATA_W-1:0]   wb_data
);
    lsu_state_t           state_q, state_d;
    logic                 we_q;
    logic [NUM_LANES-1:0] mask_q, pending_q, cur_bit, hit, clr;
    logic [ADDR_W-1:0]    addr_q    [NUM_LANES];
    logic [DATA_W-1:0]    wdata_q   [NUM_LANES];
    logic [DATA_W-1:0]    wb_data_q [NUM_LANES];
    logic [LANE_W-1:0]    cur;
    logic                 cur_any, accept, rsp_take;

    gpu_lane_prio_enc #(.N(NUM_LANES)) u_prio (
        .vec (pending_q),
        .idx (cur),
        .any (cur_any)
    );

    assign accept   = (state_q == IDLE) && req_valid;
    assign rsp_take = (state_q == WAIT_RSP) && mem_rsp_valid;
    assign cur_bit  = NUM_LANES'(1) << cur;

    // Lanes retired by a load response; stores always retire only the current lane.
`ifdef GPU_LSU_COALESCE_EN
    always_comb begin
        hit = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            hit[l] = pending_q[l] && (addr_q[l] == addr_q[cur]);
        end
    end
`else
    assign hit = cur_bit;
`endif

    always_comb begin
        state_d = state_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) state_d = (|req_mask) ? ISSUE : WRITEBACK;
            end
            ISSUE: begin
                if (mem_req_ready && cur_any) begin
                    if (we_q) begin
                        clr     = cur_bit;
                        state_d = (|(pending_q & ~cur_bit)) ? ISSUE : WRITEBACK;
                    end else begin
                        state_d = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    clr     = hit;
                    state_d = (|(pending_q & ~hit)) ? ISSUE : WRITEBACK;
                end
            end
            WRITEBACK: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            mask_q    <= '0;
            pending_q <= '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                addr_q[l]    <= '0;
                wdata_q[l]   <= '0;
                wb_data_q[l] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q      <= req_we;
                mask_q    <= req_mask;
                pending_q <= req_mask;
                for (int l = 0; l < NUM_LANES; l++) begin
                    addr_q[l]  <= req_addr[l*ADDR_W +: ADDR_W];
                    wdata_q[l] <= req_wdata[l*DATA_W +: DATA_W];
                end
            end else begin
                pending_q <= pending_q & ~clr;
            end
            if (rsp_take) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (hit[l]) wb_data_q[l] <= mem_rdata;
                end
            end
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign stall         = (state_q != IDLE);
    assign mem_req_valid = (state_q == ISSUE) && cur_any;
    assign mem_we        = mem_req_valid && we_q;
    assign mem_addr      = mem_req_valid ? addr_q[cur] : '0;
    assign mem_wdata     = mem_req_valid ? wdata_q[cur] : '0;
    assign wb_valid      = (state_q == WRITEBACK);
    assign wb_mask       = (wb_valid && !we_q) ? mask_q : '0;

    always_comb begin
        wb_data = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            wb_data[l*DATA_W +: DATA_W] = wb_data_q[l];
        end
    end
endmodule
